// File: rtl/aes_pkg.sv
// Shared types and round-count constants for the AES round-sequencing controller.
package aes_pkg;

    typedef enum logic [1:0] {
        KL128   = 2'b00,
        KL192   = 2'b01,
        KL256   = 2'b10,
        KL_RSVD = 2'b11
    } key_len_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY_EXP,
        INIT,
        ROUND,
        FINAL,
        HOLD
    } ctrl_state_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input key_len_t kl);
        case (kl)
            KL192:   nr_of = NR_192;
            KL256:   nr_of = NR_256;
            default: nr_of = NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_rnd_cnt.sv
// Loadable up/down round counter; hit_o flags that the next step lands on term_i.
module aes_rnd_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    input  logic             step_i,
    input  logic             down_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] stepVal;

    assign stepVal = down_i ? (cnt_q - ONE) : (cnt_q + ONE);
    assign hit_o   = (stepVal == term_i);
    assign cnt_o   = cnt_q;

    // Clear has priority over load, load over stepping.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (ld_i) begin
            cnt_q <= ld_val_i;
        end else if (step_i) begin
            cnt_q <= stepVal;
        end
    end

endmodule

// File: rtl/aes_ctrl_fsm_p.sv
// AES round-sequencing controller: key pre-expansion for decryption, initial
// AddRoundKey, middle rounds, final round and result hand-off with abort.
module aes_ctrl_fsm_p
    import aes_pkg::*;
#(
    parameter bit SUPPORT_DEC = 1'b1,
    parameter bit SUPPORT_192 = 1'b1,
    parameter int CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       key_len,
    input  logic             mode,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Ld_State,
    output logic             En_Func,
    output logic             Last_Rnd,
    output logic             En_Exp,
    output logic             Exp_Dir,
    output logic [CNT_W-1:0] rnd_idx,
    output logic             Busy,
    output logic             Err
);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic             dec_q, dec_d;

    logic ldState_q, enFunc_q, lastRnd_q, enExp_q, expDir_q, busy_q, outValid_q;

    key_len_t         klIn;
    logic             rsvdKl;
    logic             decIn;
    logic             accept;
    logic             cntClr, cntLd, cntStep, cntDown, cntHit;
    logic [CNT_W-1:0] cntTerm;

    assign klIn     = key_len_t'(key_len);
    assign rsvdKl   = (klIn == KL_RSVD) || ((klIn == KL192) && !SUPPORT_192);
    assign decIn    = SUPPORT_DEC && mode;
    assign in_ready = (state_q == IDLE) && !abort;
    assign accept   = in_valid && in_ready;
    assign Err      = accept && rsvdKl;

    // KEY_EXP always counts up to NR; ROUND heads for NR (enc) or 0 (dec).
    assign cntClr  = abort || (state_q inside {IDLE, FINAL, HOLD});
    assign cntLd   = (state_q == KEY_EXP) && cntHit;
    assign cntStep = state_q inside {KEY_EXP, INIT, ROUND};
    assign cntDown = dec_q && (state_q inside {INIT, ROUND});
    assign cntTerm = ((state_q == KEY_EXP) || !dec_q) ? nr_q : '0;

    aes_rnd_cnt #(
        .CNT_W (CNT_W)
    ) u_rnd_cnt (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clr_i    (cntClr),
        .ld_i     (cntLd),
        .ld_val_i (nr_q),
        .step_i   (cntStep),
        .down_i   (cntDown),
        .term_i   (cntTerm),
        .cnt_o    (rnd_idx),
        .hit_o    (cntHit)
    );

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: begin
                if (accept && !rsvdKl) begin
                    state_d = decIn ? KEY_EXP : INIT;
                    nr_d    = CNT_W'(nr_of(klIn));
                    dec_d   = decIn;
                end
            end
            KEY_EXP: if (cntHit) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (cntHit) state_d = FINAL;
            FINAL:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nr_q       <= '0;
            dec_q      <= 1'b0;
            ldState_q  <= 1'b0;
            enFunc_q   <= 1'b0;
            lastRnd_q  <= 1'b0;
            enExp_q    <= 1'b0;
            expDir_q   <= 1'b0;
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nr_q       <= nr_d;
            dec_q      <= dec_d;
            ldState_q  <= (state_d == INIT);
            enFunc_q   <= state_d inside {ROUND, FINAL};
            lastRnd_q  <= (state_d == FINAL);
            enExp_q    <= state_d inside {KEY_EXP, ROUND, FINAL};
            expDir_q   <= dec_d && (state_d inside {ROUND, FINAL});
            busy_q     <= state_d inside {KEY_EXP, INIT, ROUND, FINAL};
            outValid_q <= (state_d == HOLD);
        end
    end

    assign Ld_State  = ldState_q;
    assign En_Func   = enFunc_q;
    assign Last_Rnd  = lastRnd_q;
    assign En_Exp    = enExp_q;
    assign Exp_Dir   = expDir_q;
    assign Busy      = busy_q;
    assign out_valid = outValid_q;

endmodule
